// File: rtl/stst_pkg.sv
// Shared self-test definitions: controller state encoding, default widths and
// the partial-sum width rule used by both the comparator and its controller.
package stst_pkg;

    localparam int SYSTOLIC_SIZE_DEF    = 8;
    localparam int WEIGHT_WIDTH_DEF     = 8;
    localparam int ACTIVATION_WIDTH_DEF = 8;
    localparam int PAT_CNT_W_DEF        = 8;

    // Room for the full product plus one carry bit per doubling of accumulated terms.
    function automatic int psum_width(input int w_width, input int a_width, input int columns);
        return w_width + a_width + $clog2(columns);
    endfunction

    localparam int PARTIAL_SUM_WIDTH_DEF =
        psum_width(WEIGHT_WIDTH_DEF, ACTIVATION_WIDTH_DEF, SYSTOLIC_SIZE_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } stst_state_e;

endpackage

// File: rtl/comparator_test_controller.sv
// Steps the per-column comparator through a self-test: fetch golden value,
// present it, collect mismatch flags into a sticky fault map and counters.
module comparator_test_controller
    import stst_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = SYSTOLIC_SIZE_DEF,
    parameter int WEIGHT_WIDTH      = WEIGHT_WIDTH_DEF,
    parameter int ACTIVATION_WIDTH  = ACTIVATION_WIDTH_DEF,
    parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
    parameter int PAT_CNT_W         = PAT_CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [PAT_CNT_W-1:0]         num_patterns,
    output logic                         golden_rd_en,
    output logic [PAT_CNT_W-1:0]         golden_addr,
    input  logic [PARTIAL_SUM_WIDTH-1:0] golden_data,
    output logic [PARTIAL_SUM_WIDTH-1:0] correct_answer,
    output logic                         psum_ready,
    input  logic                         psum_valid,
    input  logic [SYSTOLIC_SIZE-1:0]     compared_results,
    output logic                         busy,
    output logic                         done,
    output logic [SYSTOLIC_SIZE-1:0]     fault_map,
    output logic [PAT_CNT_W-1:0]         fail_count,
    output logic                         first_fail_valid,
    output logic [PAT_CNT_W-1:0]         first_fail_idx
);

    localparam logic [PAT_CNT_W-1:0] CNT_ONE = {{(PAT_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PAT_CNT_W-1:0] CNT_MAX = {PAT_CNT_W{1'b1}};

    stst_state_e                  state_q, state_d;
    logic [PAT_CNT_W-1:0]         idx_q, idx_d;
    logic [PAT_CNT_W-1:0]         num_q, num_d;
    logic [PARTIAL_SUM_WIDTH-1:0] correct_answer_q, correct_answer_d;
    logic [SYSTOLIC_SIZE-1:0]     fault_map_q, fault_map_d;
    logic [PAT_CNT_W-1:0]         fail_count_q, fail_count_d;
    logic                         ff_valid_q, ff_valid_d;
    logic [PAT_CNT_W-1:0]         ff_idx_q, ff_idx_d;
    logic                         golden_rd_en_q, golden_rd_en_d;
    logic [PAT_CNT_W-1:0]         golden_addr_q, golden_addr_d;
    logic                         psum_ready_q, psum_ready_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         any_fail_s;

    // Next-state and result accumulation; abort overrides everything outside IDLE.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        num_d            = num_q;
        correct_answer_d = correct_answer_q;
        fault_map_d      = fault_map_q;
        fail_count_d     = fail_count_q;
        ff_valid_d       = ff_valid_q;
        ff_idx_d         = ff_idx_q;
        any_fail_s       = |compared_results;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    fault_map_d  = {SYSTOLIC_SIZE{1'b0}};
                    fail_count_d = {PAT_CNT_W{1'b0}};
                    ff_valid_d   = 1'b0;
                    ff_idx_d     = {PAT_CNT_W{1'b0}};
                    idx_d        = {PAT_CNT_W{1'b0}};
                    num_d        = num_patterns;
                    if (num_patterns != {PAT_CNT_W{1'b0}}) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    correct_answer_d = golden_data;
                    state_d          = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (psum_valid) begin
                    fault_map_d = fault_map_q | compared_results;
                    if (any_fail_s) begin
                        if (fail_count_q != CNT_MAX) begin
                            fail_count_d = fail_count_q + CNT_ONE;
                        end else begin
                            fail_count_d = fail_count_q;
                        end
                        if (!ff_valid_q) begin
                            ff_valid_d = 1'b1;
                            ff_idx_d   = idx_q;
                        end else begin
                            ff_valid_d = ff_valid_q;
                        end
                    end else begin
                        fail_count_d = fail_count_q;
                    end
                    if (idx_q == (num_q - CNT_ONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + CNT_ONE;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the upcoming state so they leave a flop aligned with it.
    always_comb begin
        golden_rd_en_d = (state_d == ST_FETCH);
        psum_ready_d   = (state_d == ST_WAIT);
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_DONE);
        if (state_d == ST_FETCH) begin
            golden_addr_d = idx_d;
        end else begin
            golden_addr_d = {PAT_CNT_W{1'b0}};
        end
    end

    // State, results and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            idx_q            <= {PAT_CNT_W{1'b0}};
            num_q            <= {PAT_CNT_W{1'b0}};
            correct_answer_q <= {PARTIAL_SUM_WIDTH{1'b0}};
            fault_map_q      <= {SYSTOLIC_SIZE{1'b0}};
            fail_count_q     <= {PAT_CNT_W{1'b0}};
            ff_valid_q       <= 1'b0;
            ff_idx_q         <= {PAT_CNT_W{1'b0}};
            golden_rd_en_q   <= 1'b0;
            golden_addr_q    <= {PAT_CNT_W{1'b0}};
            psum_ready_q     <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            num_q            <= num_d;
            correct_answer_q <= correct_answer_d;
            fault_map_q      <= fault_map_d;
            fail_count_q     <= fail_count_d;
            ff_valid_q       <= ff_valid_d;
            ff_idx_q         <= ff_idx_d;
            golden_rd_en_q   <= golden_rd_en_d;
            golden_addr_q    <= golden_addr_d;
            psum_ready_q     <= psum_ready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign golden_rd_en     = golden_rd_en_q;
    assign golden_addr      = golden_addr_q;
    assign correct_answer   = correct_answer_q;
    assign psum_ready       = psum_ready_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign fault_map        = fault_map_q;
    assign fail_count       = fail_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;

endmodule

// File: tb/tb_comparator_test_controller.sv
// Randomized self-checking bench for comparator_test_controller with a
// golden ROM model and a pattern-level reference of the expected results.
module tb_comparator_test_controller;
    import stst_pkg::*;

    localparam int SS  = 8;
    localparam int PW  = 8;
    localparam int PSW = psum_width(8, 8, 8);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           psum_valid = 1'b0;
    logic [PW-1:0]  num_patterns = '0;
    logic [SS-1:0]  compared_results = '0;
    logic [PSW-1:0] golden_data = '0;
    logic           golden_rd_en;
    logic [PW-1:0]  golden_addr;
    logic [PSW-1:0] correct_answer;
    logic           psum_ready;
    logic           busy;
    logic           done;
    logic [SS-1:0]  fault_map;
    logic [PW-1:0]  fail_count;
    logic           first_fail_valid;
    logic [PW-1:0]  first_fail_idx;

    int checks = 0;
    int errors = 0;

    logic [PSW-1:0] mem     [0:255];
    logic [SS-1:0]  res_tab [0:255];

    logic [SS-1:0] m_fault;
    int            m_cnt;
    logic          m_ffv;
    int            m_ffi;

    logic          rd_prev = 1'b0;
    logic [PW-1:0] addr_prev = '0;

    comparator_test_controller #(
        .SYSTOLIC_SIZE(SS), .WEIGHT_WIDTH(8), .ACTIVATION_WIDTH(8),
        .PARTIAL_SUM_WIDTH(PSW), .PAT_CNT_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_patterns(num_patterns), .golden_rd_en(golden_rd_en),
        .golden_addr(golden_addr), .golden_data(golden_data),
        .correct_answer(correct_answer), .psum_ready(psum_ready),
        .psum_valid(psum_valid), .compared_results(compared_results),
        .busy(busy), .done(done), .fault_map(fault_map),
        .fail_count(fail_count), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    // Golden ROM: data valid only in the cycle after a read strobe, junk otherwise.
    always @(posedge clk) begin
        #1;
        if (rd_prev) golden_data = mem[addr_prev];
        else         golden_data = PSW'($urandom);
        rd_prev   = golden_rd_en;
        addr_prev = golden_addr;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        chk_eq({tag, "_fault_map"}, fault_map, m_fault);
        chk_eq({tag, "_fail_count"}, fail_count, m_cnt);
        chk_eq({tag, "_ff_valid"}, first_fail_valid, m_ffv);
        chk_eq({tag, "_ff_idx"}, first_fail_idx, m_ffi);
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_done"}, done, 0);
        chk_eq({tag, "_ready"}, psum_ready, 0);
        chk_eq({tag, "_rd_en"}, golden_rd_en, 0);
        chk_eq({tag, "_addr"}, golden_addr, 0);
        chk_eq({tag, "_ca"}, correct_answer, 0);
        m_fault = '0; m_cnt = 0; m_ffv = 1'b0; m_ffi = 0;
        check_results(tag);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = PSW'($urandom);
    endtask

    task automatic fill_res();
        for (int i = 0; i < 256; i++) res_tab[i] = ($urandom_range(0, 1) == 1) ? SS'($urandom) : '0;
    endtask

    // One full test: n patterns, `hold` idle WAIT cycles each, optional abort
    // (with a same-cycle valid sample) at pattern abort_pat, optional input noise.
    task automatic run_test(input int n, input int hold, input int abort_pat, input bit noise);
        int k, hc, cyc, exp_cyc;
        bit fin, ab;
        m_fault = '0; m_cnt = 0; m_ffv = 1'b0; m_ffi = 0;
        k = 0; hc = 0; fin = 0; ab = 0;
        exp_cyc = 3 * n + 1 + n * hold;
        start = 1'b1; abort = 1'b0; psum_valid = 1'b0; num_patterns = PW'(n);
        @(negedge clk);
        cyc = 1;
        while (!fin && cyc < 3000) begin
            start = 1'b0; abort = 1'b0; psum_valid = 1'b0;
            compared_results = SS'($urandom);
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                num_patterns = PW'($urandom);
                psum_valid = ($urandom_range(0, 1) == 1);
            end
            if (ab) begin
                chk_eq("abort_busy", busy, 0);
                chk_eq("abort_done", done, 0);
                start = 1'b0;
                fin = 1;
            end else if (done) begin
                chk_eq("done_cycle", cyc, exp_cyc);
                chk_eq("done_patterns", k, n);
                start = 1'b0;
                fin = 1;
            end else if (golden_rd_en) begin
                chk_eq("rom_addr", golden_addr, k);
            end else if (psum_ready) begin
                chk_eq("correct_answer", correct_answer, mem[k]);
                if (hc < hold) begin
                    hc++;
                    psum_valid = 1'b0;
                end else begin
                    psum_valid = 1'b1;
                    compared_results = res_tab[k];
                    if (k == abort_pat) begin
                        abort = 1'b1;
                        ab = 1;
                    end else begin
                        m_fault |= res_tab[k];
                        if (res_tab[k] != '0) begin
                            if (m_cnt < 255) m_cnt++;
                            if (!m_ffv) begin m_ffv = 1'b1; m_ffi = k; end
                        end
                        k++;
                        hc = 0;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) chk_eq("timeout", 0, 1);
        start = 1'b0; abort = 1'b0; psum_valid = 1'b0;
        if (!ab) begin
            chk_eq("done_pulse_end", done, 0);
            chk_eq("idle_busy", busy, 0);
        end
        check_results("end");
        psum_valid = 1'b1; compared_results = '1;
        repeat (2) @(negedge clk);
        psum_valid = 1'b0;
        check_results("hold");
    endtask

    initial begin
        int n, ab_pat, guard;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin mem[i] = PSW'(10 * (i + 1)); res_tab[i] = '0; end
        run_test(4, 0, -1, 0);

        fill_mem();
        res_tab[0] = 8'h00; res_tab[1] = 8'h05; res_tab[2] = 8'h81;
        run_test(3, 0, -1, 0);
        chk_eq("t2_fault_const", fault_map, 32'h85);
        chk_eq("t2_cnt_const", fail_count, 32'd2);
        chk_eq("t2_ffi_const", first_fail_idx, 32'd1);

        fill_mem(); fill_res();
        run_test(2, 5, -1, 0);

        fill_mem(); fill_res();
        res_tab[0] = 8'h10; res_tab[1] = 8'h0F;
        run_test(5, 0, 1, 0);
        chk_eq("abort_keep_bits", fault_map, 32'h10);

        start = 1'b1; abort = 1'b1; num_patterns = 8'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_eq("start_abort_idle_busy", busy, 0);
        check_results("start_abort_idle");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_eq("abort_idle_busy", busy, 0);

        run_test(0, 0, -1, 1);

        for (int t = 0; t < 8; t++) begin
            fill_mem(); fill_res();
            n = $urandom_range(1, 12);
            ab_pat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_test(n, $urandom_range(0, 3), ab_pat, 1);
        end

        fill_mem(); fill_res();
        start = 1'b1; num_patterns = 8'd3;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!psum_ready && guard < 20) begin @(negedge clk); guard++; end
        chk_eq("reach_wait", psum_ready, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_test(3, 1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator_test_controller.md
Name: comparator_test_controller

Overview:
Sequences the per-column comparator during array self-test. For each test pattern it fetches the golden partial sum from the golden-answer ROM and drives it to the comparator as correct_answer. It then waits for the systolic array's partial sums and accumulates the comparator's per-column mismatch flags into a sticky fault map for the self-recovery logic. The block sits between the self-test sequencer (start/done) and the comparator/golden ROM.

Parameters:
SYSTOLIC_SIZE, 8, number of array columns compared per pattern
WEIGHT_WIDTH, 8, weight operand width
ACTIVATION_WIDTH, 8, activation operand width
PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(SYSTOLIC_SIZE), golden/partial-sum width
PAT_CNT_W, 8, pattern index/count width; maximum of 2^PAT_CNT_W-1 patterns

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle test start request; honoured only in IDLE
abort  in  1  terminates a running test
num_patterns  in  PAT_CNT_W  number of patterns; sampled on an accepted start
golden_rd_en  out  1  golden ROM read strobe
golden_addr  out  PAT_CNT_W  golden ROM address (pattern index)
golden_data  in  PARTIAL_SUM_WIDTH  ROM data; valid exactly 1 cycle after golden_rd_en
correct_answer  out  PARTIAL_SUM_WIDTH  registered golden value driven to the comparator
psum_ready  out  1  controller ready to sample comparator results
psum_valid  in  1  array partial sums valid, so compared_results is valid this cycle
compared_results  in  SYSTOLIC_SIZE  comparator mismatch flags (1 = column mismatch)
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse on normal completion
fault_map  out  SYSTOLIC_SIZE  sticky OR of compared_results over the current test
fail_count  out  PAT_CNT_W  patterns with at least one mismatch; saturates at all-ones
first_fail_valid  out  1  at least one failing pattern recorded
first_fail_idx  out  PAT_CNT_W  index of the first failing pattern

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset is asynchronous and takes effect mid-test as well; the test is lost.
- FSM states: IDLE, FETCH, LOAD, WAIT, DONE.
- IDLE, start=1 with num_patterns!=0:
  - clear fault_map, fail_count, first_fail_valid and first_fail_idx;
  - set idx=0 and latch num_patterns;
  - next state FETCH.
- IDLE, start=1 with num_patterns==0: clear the results, go to DONE. done pulses the next cycle.
- FETCH: golden_rd_en=1 and golden_addr=idx for exactly one cycle. Next state LOAD.
- LOAD: register golden_data into correct_answer. Next state WAIT.
- WAIT:
  - psum_ready=1.
  - On psum_valid=1, sample compared_results in the same cycle and update fault_map |= compared_results.
  - If any bit of compared_results is set: fail_count increments (saturating), and if first_fail_valid==0, set first_fail_idx=idx and first_fail_valid=1.
  - Then, if idx==latched_num-1, go to DONE; otherwise idx++ and go to FETCH.
- DONE: done=1 for one cycle. Next state IDLE.
- psum_ready=0 outside WAIT. psum_valid outside WAIT is ignored and causes no update.
- correct_answer holds its value until the next LOAD. It is not cleared at test end.
- start while busy is ignored. num_patterns changes while busy have no effect.
- abort=1 in any non-IDLE state:
  - go to IDLE on the next edge, with no done;
  - results retain the partial values accumulated so far;
  - abort has priority over a same-cycle psum_valid, so that sample is discarded.
- abort in IDLE has no effect. start and abort asserted together in IDLE: abort wins and start is ignored.
- Timing: minimum 3 cycles per pattern. With psum_valid already high, done asserts 3N+1 cycles after the start cycle.
- fault_map, fail_count and first_fail_* remain stable after done until the next accepted start.

Decomposition:
- Shared package stst_pkg holds:
  - FSM state enum (IDLE/FETCH/LOAD/WAIT/DONE);
  - the default width constants;
  - the PARTIAL_SUM_WIDTH derivation function, so the comparator and controller agree.
- No sub-module. The comparator stays a separate instance at the parent, fed by correct_answer.

Test Plan:
- num_patterns=4, golden=[10,20,30,40], all psum equal to golden, psum_valid always high -> done at cycle 13; fault_map=0, fail_count=0, first_fail_valid=0.
- num_patterns=3, compared_results=8'h00, 8'h05, 8'h81 -> fault_map=8'h85, fail_count=2, first_fail_idx=1, first_fail_valid=1.
- num_patterns=2, psum_valid held low for 5 cycles in each WAIT -> golden_rd_en pulses once per pattern at addresses 0 then 1; done at cycle 17; no sample is taken while psum_valid=0.
- Abort during WAIT of pattern 2 of 5, with psum_valid=1 in the same cycle -> IDLE next cycle, no done, busy=0, that sample is discarded, earlier fault bits kept.
- start with num_patterns=0 -> done the next cycle, all results 0. A second start asserted while busy -> ignored.
- Reset asserted mid-WAIT -> all outputs 0 immediately. A new start after reset release runs normally from idx=0.
